// File: rtl/rr_lock_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that locks a grant across a multi-cycle transfer; 1-cycle request-to-grant latency.
// No backpressure input: an owner releases via last, dropping req, or by hitting MAX_HOLD (timeout pulse).
module rr_lock_arbiter #(
  parameter int REQ_WIDTH = 8,
  parameter int MAX_HOLD  = 16,
  parameter int ID_WIDTH  = $clog2(REQ_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_WIDTH-1:0] req,
  input  logic                 last,
  output logic [REQ_WIDTH-1:0] gnt,
  output logic                 gnt_valid,
  output logic [ID_WIDTH-1:0]  gnt_id,
  output logic                 timeout
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_n;
  logic [HC_W-1:0]      hold_cnt, hold_cnt_n;
  logic [ID_WIDTH-1:0]  ptr, ptr_n, gnt_id_n, win_id;
  logic [REQ_WIDTH-1:0] gnt_n;
  logic                 timeout_n, win_found;
  logic                 rel_drop, rel_last, rel_max;

  // Search starts one past the previous owner so the last winner has lowest priority.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 1; i <= REQ_WIDTH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= REQ_WIDTH) idx = idx - REQ_WIDTH;
      if (!win_found && req[ID_WIDTH'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(idx);
      end
    end
  end

  assign rel_drop = !req[gnt_id];
  assign rel_last = last;
  assign rel_max  = (hold_cnt == HC_W'(MAX_HOLD));

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    hold_cnt_n = hold_cnt;
    ptr_n      = ptr;
    timeout_n  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n         = BUSY;
          gnt_n           = '0;
          gnt_n[win_id]   = 1'b1;
          gnt_id_n        = win_id;
          hold_cnt_n      = HC_W'(1);
        end
      end
      BUSY: begin
        if (rel_drop || rel_last || rel_max) begin
          state_n    = IDLE;
          gnt_n      = '0;
          gnt_id_n   = '0;
          hold_cnt_n = '0;
          ptr_n      = gnt_id;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_n  = rel_max && !rel_drop && !rel_last;
        end else begin
          hold_cnt_n = hold_cnt + HC_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      ptr      <= ID_WIDTH'(REQ_WIDTH - 1);
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      hold_cnt <= hold_cnt_n;
      ptr      <= ptr_n;
      timeout  <= timeout_n;
    end
  end

  assign gnt_valid = (state == BUSY);

endmodule
